// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register file.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_regfile_core.sv
// Register storage with byte-strobe write merge and combinational read mux.
module axi_regfile_core
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int IDX_W      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [IDX_W-1:0]               ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (we && (widx == IDX_W'(gi))) begin
          for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (wstrb[b]) word_reg[b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end

      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rdata = reg_out[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers with independent read/write FSMs.
// Define AXI_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int BASE_ADDR  = 0,
  parameter int NUM_REGS   = 4
) (
  input  logic                           s0_axi_aclk,
  input  logic                           s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s0_axi_wstrb,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

`ifdef AXI_REGFILE_SLVERR_EN
  localparam logic [RESP_WIDTH-1:0] ERR_RESP = RESP_WIDTH'(RESP_SLVERR);
`else
  localparam logic [RESP_WIDTH-1:0] ERR_RESP = RESP_WIDTH'(RESP_OKAY);
`endif
  localparam logic [RESP_WIDTH-1:0] OK_RESP = RESP_WIDTH'(RESP_OKAY);

  wr_state_t wr_state_reg;
  rd_state_t rd_state_reg;

  logic                    awready_reg, wready_reg, bvalid_reg;
  logic [RESP_WIDTH-1:0]   bresp_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] wstrb_reg;

  logic                    arready_reg, rvalid_reg;
  logic [RESP_WIDTH-1:0]   rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = s0_axi_awvalid & awready_reg;
  assign w_hs  = s0_axi_wvalid  & wready_reg;
  assign ar_hs = s0_axi_arvalid & arready_reg;

  // The write commits on the edge where the later of AW/W lands, so the
  // payload comes from the live bus for whichever half arrives last.
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_commit;

  always_comb begin
    wr_addr   = awaddr_reg;
    wr_data   = wdata_reg;
    wr_strb   = wstrb_reg;
    wr_commit = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        wr_addr   = s0_axi_awaddr;
        wr_data   = s0_axi_wdata;
        wr_strb   = s0_axi_wstrb;
        wr_commit = aw_hs & w_hs;
      end
      W_WAIT_DATA: begin
        wr_data   = s0_axi_wdata;
        wr_strb   = s0_axi_wstrb;
        wr_commit = w_hs;
      end
      W_WAIT_ADDR: begin
        wr_addr   = s0_axi_awaddr;
        wr_commit = aw_hs;
      end
      default: ;
    endcase
  end

  logic [ADDR_WIDTH-1:0] wr_off, rd_off;
  logic                  wr_ok, rd_ok;
  assign wr_off = wr_addr - ADDR_WIDTH'(BASE_ADDR);
  assign rd_off = s0_axi_araddr - ADDR_WIDTH'(BASE_ADDR);
  assign wr_ok  = (wr_off[1:0] == 2'b00) && ((wr_off >> 2) < ADDR_WIDTH'(NUM_REGS));
  assign rd_ok  = (rd_off[1:0] == 2'b00) && ((rd_off >> 2) < ADDR_WIDTH'(NUM_REGS));

  logic [DATA_WIDTH-1:0] core_rdata;

  axi_regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_core (
    .clk     (s0_axi_aclk),
    .rst_n   (s0_axi_aresetn),
    .we      (wr_commit & wr_ok),
    .widx    (wr_off[IDX_W+1:2]),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .ridx    (rd_off[IDX_W+1:2]),
    .rdata   (core_rdata),
    .reg_out (reg_out)
  );

  // Readies come up from reset low and assert on the first edge in W_IDLE.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wr_state_reg <= W_IDLE;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= '0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_reg  <= s0_axi_awaddr;
            awready_reg <= 1'b0;
          end
          if (w_hs) begin
            wdata_reg  <= s0_axi_wdata;
            wstrb_reg  <= s0_axi_wstrb;
            wready_reg <= 1'b0;
          end
          if (aw_hs && w_hs) begin
            bvalid_reg   <= 1'b1;
            bresp_reg    <= wr_ok ? OK_RESP : ERR_RESP;
            wr_state_reg <= W_RESP;
          end else if (aw_hs) begin
            wr_state_reg <= W_WAIT_DATA;
          end else if (w_hs) begin
            wr_state_reg <= W_WAIT_ADDR;
          end else begin
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
          end
        end
        W_WAIT_DATA: begin
          if (w_hs) begin
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b1;
            bresp_reg    <= wr_ok ? OK_RESP : ERR_RESP;
            wr_state_reg <= W_RESP;
          end
        end
        W_WAIT_ADDR: begin
          if (aw_hs) begin
            awready_reg  <= 1'b0;
            bvalid_reg   <= 1'b1;
            bresp_reg    <= wr_ok ? OK_RESP : ERR_RESP;
            wr_state_reg <= W_RESP;
          end
        end
        W_RESP: begin
          if (s0_axi_bready) begin
            bvalid_reg   <= 1'b0;
            bresp_reg    <= '0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            wr_state_reg <= W_IDLE;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rd_state_reg <= R_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= '0;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b1;
            rdata_reg    <= rd_ok ? core_rdata : '0;
            rresp_reg    <= rd_ok ? OK_RESP : ERR_RESP;
            rd_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (s0_axi_rready) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  assign s0_axi_awready = awready_reg;
  assign s0_axi_wready  = wready_reg;
  assign s0_axi_bvalid  = bvalid_reg;
  assign s0_axi_bresp   = bresp_reg;
  assign s0_axi_arready = arready_reg;
  assign s0_axi_rvalid  = rvalid_reg;
  assign s0_axi_rresp   = rresp_reg;
  assign s0_axi_rdata   = rdata_reg;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile; expectations follow AXI_REGFILE_SLVERR_EN.
module tb_axi_lite_regfile;

  logic         s0_axi_aclk = 1'b0;
  logic         s0_axi_aresetn;
  logic [7:0]   s0_axi_awaddr;
  logic         s0_axi_awvalid;
  logic         s0_axi_awready;
  logic [31:0]  s0_axi_wdata;
  logic [3:0]   s0_axi_wstrb;
  logic         s0_axi_wvalid;
  logic         s0_axi_wready;
  logic [2:0]   s0_axi_bresp;
  logic         s0_axi_bvalid;
  logic         s0_axi_bready;
  logic [7:0]   s0_axi_araddr;
  logic         s0_axi_arvalid;
  logic         s0_axi_arready;
  logic [31:0]  s0_axi_rdata;
  logic [2:0]   s0_axi_rresp;
  logic         s0_axi_rvalid;
  logic         s0_axi_rready;
  logic [127:0] reg_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AXI_REGFILE_SLVERR_EN
  localparam logic [2:0] EXP_ERR = 3'd2;
`else
  localparam logic [2:0] EXP_ERR = 3'd0;
`endif

  axi_lite_regfile dut (
    .s0_axi_aclk    (s0_axi_aclk),
    .s0_axi_aresetn (s0_axi_aresetn),
    .s0_axi_awaddr  (s0_axi_awaddr),
    .s0_axi_awvalid (s0_axi_awvalid),
    .s0_axi_awready (s0_axi_awready),
    .s0_axi_wdata   (s0_axi_wdata),
    .s0_axi_wstrb   (s0_axi_wstrb),
    .s0_axi_wvalid  (s0_axi_wvalid),
    .s0_axi_wready  (s0_axi_wready),
    .s0_axi_bresp   (s0_axi_bresp),
    .s0_axi_bvalid  (s0_axi_bvalid),
    .s0_axi_bready  (s0_axi_bready),
    .s0_axi_araddr  (s0_axi_araddr),
    .s0_axi_arvalid (s0_axi_arvalid),
    .s0_axi_arready (s0_axi_arready),
    .s0_axi_rdata   (s0_axi_rdata),
    .s0_axi_rresp   (s0_axi_rresp),
    .s0_axi_rvalid  (s0_axi_rvalid),
    .s0_axi_rready  (s0_axi_rready),
    .reg_out        (reg_out)
  );

  always #5 s0_axi_aclk = ~s0_axi_aclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge s0_axi_aclk);
    #1;
  endtask

  // Simultaneous AW+W with bready held high: response one cycle after, gone the next.
  task automatic write_txn(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] exp_resp);
    s0_axi_awaddr  = addr;
    s0_axi_awvalid = 1'b1;
    s0_axi_wdata   = data;
    s0_axi_wstrb   = strb;
    s0_axi_wvalid  = 1'b1;
    s0_axi_bready  = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    chk($sformatf("wr_bvalid_%0h", addr), s0_axi_bvalid, 1'b1);
    chk($sformatf("wr_bresp_%0h", addr), s0_axi_bresp, exp_resp);
    tick();
    chk($sformatf("wr_bdone_%0h", addr), s0_axi_bvalid, 1'b0);
  endtask

  task automatic read_txn(input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [2:0] exp_resp);
    s0_axi_araddr  = addr;
    s0_axi_arvalid = 1'b1;
    s0_axi_rready  = 1'b1;
    tick();
    s0_axi_arvalid = 1'b0;
    chk($sformatf("rd_rvalid_%0h", addr), s0_axi_rvalid, 1'b1);
    chk($sformatf("rd_rdata_%0h", addr), s0_axi_rdata, exp_data);
    chk($sformatf("rd_rresp_%0h", addr), s0_axi_rresp, exp_resp);
    tick();
    chk($sformatf("rd_rdone_%0h", addr), s0_axi_rvalid, 1'b0);
    s0_axi_rready = 1'b0;
  endtask

  logic [31:0] m [4];

  initial begin
    s0_axi_aresetn = 1'b0;
    s0_axi_awaddr  = '0;
    s0_axi_awvalid = 1'b0;
    s0_axi_wdata   = '0;
    s0_axi_wstrb   = '0;
    s0_axi_wvalid  = 1'b0;
    s0_axi_bready  = 1'b0;
    s0_axi_araddr  = '0;
    s0_axi_arvalid = 1'b0;
    s0_axi_rready  = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = '0;

    // Reset state
    tick();
    tick();
    chk("rst_awready", s0_axi_awready, 1'b0);
    chk("rst_wready", s0_axi_wready, 1'b0);
    chk("rst_arready", s0_axi_arready, 1'b0);
    chk("rst_valids", {s0_axi_bvalid, s0_axi_rvalid}, 2'b00);
    chk("rst_resp_data", {s0_axi_bresp, s0_axi_rresp, s0_axi_rdata}, '0);
    chk("rst_reg_out", reg_out, '0);
    s0_axi_aresetn = 1'b1;
    chk("rel_awready_pre_edge", s0_axi_awready, 1'b0);
    tick();
    chk("rel_readies", {s0_axi_awready, s0_axi_wready, s0_axi_arready}, 3'b111);

    // Simultaneous AW+W to 0x04
    write_txn(8'h04, 32'hDEADBEEF, 4'hF, 3'd0);
    m[1] = 32'hDEADBEEF;
    chk("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);
    chk("readies_back", {s0_axi_awready, s0_axi_wready}, 2'b11);

    // W three cycles ahead of AW, partial strobe over 0xAAAAAAAA
    write_txn(8'h00, 32'hAAAAAAAA, 4'hF, 3'd0);
    s0_axi_wdata  = 32'h11223344;
    s0_axi_wstrb  = 4'h3;
    s0_axi_wvalid = 1'b1;
    s0_axi_bready = 1'b1;
    tick();
    s0_axi_wvalid = 1'b0;
    chk("wfirst_wready", s0_axi_wready, 1'b0);
    chk("wfirst_awready", s0_axi_awready, 1'b1);
    tick();
    tick();
    chk("wfirst_no_bvalid", s0_axi_bvalid, 1'b0);
    chk("wfirst_reg0_unchanged", reg_out[31:0], 32'hAAAAAAAA);
    s0_axi_awaddr  = 8'h00;
    s0_axi_awvalid = 1'b1;
    tick();
    s0_axi_awvalid = 1'b0;
    m[0] = 32'hAAAA3344;
    chk("wfirst_bvalid", s0_axi_bvalid, 1'b1);
    chk("wfirst_reg0", reg_out[31:0], 32'hAAAA3344);
    tick();
    chk("wfirst_bdone", s0_axi_bvalid, 1'b0);
    read_txn(8'h00, 32'hAAAA3344, 3'd0);

    // Read 0x04 with rready held low for 5 cycles
    s0_axi_araddr  = 8'h04;
    s0_axi_arvalid = 1'b1;
    s0_axi_rready  = 1'b0;
    tick();
    s0_axi_arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_c%0d", c), {s0_axi_rvalid, s0_axi_arready, s0_axi_rdata, s0_axi_rresp},
          {1'b1, 1'b0, 32'hDEADBEEF, 3'd0});
      if (c < 4) tick();
    end
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_rready = 1'b0;
    chk("stall_done", {s0_axi_rvalid, s0_axi_arready}, 2'b01);

    // Out-of-range write/read, plus a misaligned read
    write_txn(8'h40, 32'h12345678, 4'hF, EXP_ERR);
    chk("oor_no_change", reg_out, {m[3], m[2], m[1], m[0]});
    read_txn(8'h40, 32'h0, EXP_ERR);
    read_txn(8'h06, 32'h0, EXP_ERR);

    // Same-edge read and write of register 2
    write_txn(8'h08, 32'd5, 4'hF, 3'd0);
    m[2] = 32'd5;
    s0_axi_araddr  = 8'h08;
    s0_axi_arvalid = 1'b1;
    s0_axi_awaddr  = 8'h08;
    s0_axi_awvalid = 1'b1;
    s0_axi_wdata   = 32'd9;
    s0_axi_wstrb   = 4'hF;
    s0_axi_wvalid  = 1'b1;
    s0_axi_bready  = 1'b0;
    s0_axi_rready  = 1'b0;
    tick();
    s0_axi_arvalid = 1'b0;
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    m[2] = 32'd9;
    chk("same_edge_rdata", s0_axi_rdata, 32'd5);
    chk("same_edge_valids", {s0_axi_rvalid, s0_axi_bvalid}, 2'b11);
    chk("same_edge_reg2", reg_out, {m[3], m[2], m[1], m[0]});
    s0_axi_bready = 1'b1;
    s0_axi_rready = 1'b1;
    tick();
    s0_axi_rready = 1'b0;
    chk("same_edge_done", {s0_axi_rvalid, s0_axi_bvalid}, 2'b00);
    read_txn(8'h08, 32'd9, 3'd0);

    // Reset while holding a write response
    s0_axi_awaddr  = 8'h0C;
    s0_axi_awvalid = 1'b1;
    s0_axi_wdata   = 32'h77;
    s0_axi_wstrb   = 4'hF;
    s0_axi_wvalid  = 1'b1;
    s0_axi_bready  = 1'b0;
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid  = 1'b0;
    chk("wresp_hold_bvalid", s0_axi_bvalid, 1'b1);
    chk("wresp_reg3", reg_out[127:96], 32'h77);
    #2;
    s0_axi_aresetn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m[i] = '0;
    chk("async_rst_bvalid", s0_axi_bvalid, 1'b0);
    chk("async_rst_regs", reg_out, '0);
    chk("async_rst_readies", {s0_axi_awready, s0_axi_wready, s0_axi_arready}, 3'b000);
    tick();
    s0_axi_aresetn = 1'b1;
    s0_axi_bready  = 1'b1;
    chk("rel2_awready_pre_edge", s0_axi_awready, 1'b0);
    tick();
    chk("rel2_readies", {s0_axi_awready, s0_axi_wready, s0_axi_arready}, 3'b111);
    chk("rel2_bvalid", s0_axi_bvalid, 1'b0);
    read_txn(8'h04, 32'h0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 8, address width.
- RESP_WIDTH, 3, response width.
- BASE_ADDR, 0, byte address of register 0.
- NUM_REGS, 4, number of registers, power of two, maximum 16.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- s0_axi_aclk, in, 1, the single clock.
- s0_axi_aresetn, in, 1, reset; asynchronous, active-low.
- s0_axi_awaddr, in, ADDR_WIDTH; s0_axi_awvalid, in, 1; s0_axi_awready, out, 1: write address channel.
- s0_axi_wdata, in, DATA_WIDTH; s0_axi_wstrb, in, DATA_WIDTH/8; s0_axi_wvalid, in, 1; s0_axi_wready, out, 1: write data channel.
- s0_axi_bresp, out, RESP_WIDTH; s0_axi_bvalid, out, 1; s0_axi_bready, in, 1: write response channel.
- s0_axi_araddr, in, ADDR_WIDTH; s0_axi_arvalid, in, 1; s0_axi_arready, out, 1: read address channel.
- s0_axi_rdata, out, DATA_WIDTH; s0_axi_rresp, out, RESP_WIDTH; s0_axi_rvalid, out, 1; s0_axi_rready, in, 1: read data channel.
- reg_out, out, NUM_REGS*DATA_WIDTH: flat view of all registers, register 0 in the LSBs.

Function
REQ-003 Write FSM SHALL have the states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR and W_RESP.
REQ-004 In W_IDLE, awready=1 and wready=1; AW and W SHALL be accepted independently; each handshake latches its payload and deasserts its own ready.
- AW only: go to W_WAIT_DATA.
- W only: go to W_WAIT_ADDR.
- Both in the same cycle: go directly to W_RESP.
REQ-005 Register update SHALL occur on the edge where the second of AW/W completes, with byte lane i written only if wstrb[i]=1.
REQ-006 Register index SHALL be (awaddr-BASE_ADDR)>>2; the address is in range if it is word-aligned and the index is below NUM_REGS.
REQ-007 In W_RESP, bvalid=1 and bresp is held stable until bready=1; on that handshake go to W_IDLE and reassert awready and wready on the next cycle.
REQ-008 Read FSM SHALL have the states R_IDLE and R_DATA.
REQ-009 In R_IDLE, arready=1; on the AR handshake, latch rdata and rresp and go to R_DATA, giving one-cycle latency from handshake to rvalid.
REQ-010 In R_DATA, arready=0, rvalid=1, and rdata/rresp are held stable until rready=1, then go to R_IDLE.
REQ-011 A read and a write to the same register completing on the same edge SHALL return the pre-write value.
REQ-012 Read and write FSMs SHALL run concurrently and independently.
REQ-013 bresp/rresp SHALL be OKAY=0 for in-range accesses; out-of-range handling is set by REQ-016.
REQ-014 Out-of-range writes SHALL modify no register.

Reset
REQ-015 While s0_axi_aresetn=0, the following SHALL hold asynchronously:
- all registers 0, reg_out 0;
- awready/wready/arready 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0;
- FSMs in W_IDLE and R_IDLE; any in-flight transaction is dropped.
Readies SHALL assert on the first clock edge after release.

Configuration
REQ-016 Macro AXI_REGFILE_SLVERR_EN SHALL control out-of-range responses:
- Defined: out-of-range accesses respond SLVERR=2, and reads return rdata=0.
- Undefined: out-of-range accesses respond OKAY=0, and reads return rdata=0.

Structure
REQ-017 Package axi_lite_pkg SHALL hold the RESP_OKAY and RESP_SLVERR constants and the write-state and read-state enum typedefs.
REQ-018 Sub-module axi_regfile_core SHALL hold the register array, the byte-strobe merge and the combinational read mux; the FSMs stay in the top module.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Simultaneous AW+W to 0x04, data 0xDEADBEEF, wstrb 0xF, bready=1 -> bvalid 1 cycle later, bresp 0; reg_out[63:32]=0xDEADBEEF.
- W valid 3 cycles before AW to 0x00, data 0x11223344, wstrb 0x3 over an initial value 0xAAAAAAAA -> register 0 reads 0xAAAA3344.
- Read 0x04 with rready held 0 for 5 cycles -> rvalid and rdata=0xDEADBEEF stable throughout; arready=0 until the rready handshake.
- Write 0x40 with the macro defined -> bresp 2, no register change; read 0x40 -> rresp 2, rdata 0; macro undefined -> both responses 0.
- Same-edge read of 0x08 (holding 5) and write of 9 to 0x08 -> rdata 5; a subsequent read returns 9.
- Reset asserted in W_RESP with bvalid=1 -> bvalid drops immediately, all registers 0, awready=1 one edge after release.
